// File: rtl/fetch_unit_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package fetch_unit_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] ins;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & ~XLEN'(3);
  endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// Fetch stage boundary: imem request/response, instruction handoff to core, redirect.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [ILEN-1:0] imem_rsp_data;
  logic            ins_valid;
  logic            ins_ready;
  logic [ILEN-1:0] ins;
  logic [XLEN-1:0] ins_pc;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output imem_req_valid, imem_req_addr, ins_valid, ins, ins_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, ins_ready,
           redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, ins_valid, ins, ins_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, ins_ready,
           redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous {pc,ins} buffer: push visible at head next cycle, flush beats push.
// Pop on empty and push on full (without pop) are ignored.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH) + 1,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_dat,
  output fetch_entry_t head_dat,
  output logic [CW-1:0] count
);
  fetch_entry_t    mem_q [DEPTH];
  logic [PW-1:0]   wr_q, rd_q;
  logic [CW-1:0]   count_q;
  logic            do_push, do_pop;

  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && !flush && ((count_q != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PW'(1);
      if (do_pop)  rd_q <= rd_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_dat = mem_q[rd_q];
  assign count    = count_q;
endmodule

// File: rtl/fetch_unit.sv
// Fetch PC owner: one outstanding imem request, buffered words to core, min latency fire->ins_valid 2 cycles.
// Issue stalls while a request is outstanding or the buffer could overflow; redirect flushes and discards in-flight data.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int              FIFO_DEPTH = 2
) (
  input logic        clk,
  input logic        rst,
  fetch_unit_if.master io
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            outstanding_q, outstanding_d;
  logic            discard_q, discard_d;

  logic [CW-1:0]   count;
  fetch_entry_t    head_dat, push_dat;
  logic            req_vld, req_fire, rsp_acc, push, pop, ins_vld;

  assign req_vld = !rst && !io.redirect_valid && !outstanding_q &&
                   ((count + CW'(outstanding_q)) < CW'(FIFO_DEPTH));
  assign req_fire = req_vld && io.imem_req_ready;
  assign rsp_acc  = io.imem_rsp_valid && outstanding_q;
  assign push     = rsp_acc && !discard_q && !io.redirect_valid;
  assign ins_vld  = (count != '0);
  assign pop      = ins_vld && io.ins_ready;

  // fetch_pc has advanced exactly once since the kept request issued; any redirect
  // in between would have armed discard, so pc-4 is the request address.
  assign push_dat = '{pc: fetch_pc_q - XLEN'(4), ins: io.imem_rsp_data};

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .flush    (io.redirect_valid),
    .push_dat (push_dat),
    .head_dat (head_dat),
    .count    (count)
  );

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    if (rsp_acc) begin
      outstanding_d = 1'b0;
      discard_d     = 1'b0;
    end
    if (req_fire) outstanding_d = 1'b1;
    if (io.redirect_valid && outstanding_q && !io.imem_rsp_valid) discard_d = 1'b1;
    if (io.redirect_valid)  fetch_pc_d = align_pc(io.redirect_pc);
    else if (req_fire)      fetch_pc_d = fetch_pc_q + XLEN'(4);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= 1'b0;
      discard_q     <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  assign io.imem_req_valid = req_vld;
  assign io.imem_req_addr  = fetch_pc_q;
  assign io.ins_valid      = ins_vld;
  assign io.ins            = head_dat.ins;
  assign io.ins_pc         = head_dat.pc;
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized fetch_unit bench against a queue-based model of the fetch stage, plus directed scenarios.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  fetch_unit_if io();

  fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: fetch address, one-outstanding flag, pending discard, buffered {pc,ins} words.
  logic [31:0] m_pc     = RPC;
  bit          m_out    = 1'b0;
  bit          m_disc   = 1'b0;
  logic [31:0] m_req_pc = 32'h0;
  logic [63:0] m_q[$];
  bit          e_req;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic drive(input bit r, input bit rdy, input bit rv, input bit ir,
                       input bit rd, input logic [31:0] rpc);
    @(negedge clk);
    rst                = r;
    io.imem_req_ready  = rdy;
    io.imem_rsp_valid  = rv;
    io.imem_rsp_data   = m_out ? memfn(m_req_pc) : $urandom;
    io.ins_ready       = ir;
    io.redirect_valid  = rd;
    io.redirect_pc     = rpc;
    #1;
    e_req = !r && !rd && !m_out && ((m_q.size() + int'(m_out)) < DEPTH);
    chk("req_valid", 32'(io.imem_req_valid), 32'(e_req));
    if (e_req) chk("req_addr", io.imem_req_addr, m_pc);
    chk("ins_valid", 32'(io.ins_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      chk("ins_pc", io.ins_pc, m_q[0][63:32]);
      chk("ins", io.ins, m_q[0][31:0]);
    end
  endtask

  task automatic tick();
    bit fire, acc;
    if (rst) begin
      m_pc = RPC; m_out = 1'b0; m_disc = 1'b0; m_q.delete();
    end else begin
      fire = e_req && io.imem_req_ready;
      acc  = io.imem_rsp_valid && m_out;
      if (m_q.size() != 0 && io.ins_ready) void'(m_q.pop_front());
      if (io.redirect_valid) m_q.delete();
      else if (acc && !m_disc) m_q.push_back({m_req_pc, io.imem_rsp_data});
      if (io.redirect_valid && m_out && !io.imem_rsp_valid) m_disc = 1'b1;
      else if (acc) m_disc = 1'b0;
      if (acc) m_out = 1'b0;
      if (fire) begin m_out = 1'b1; m_req_pc = m_pc; end
      if (io.redirect_valid) m_pc = io.redirect_pc & 32'hFFFF_FFFC;
      else if (fire) m_pc = m_pc + 32'd4;
    end
    @(posedge clk);
  endtask

  task automatic step(input bit r, input bit rdy, input bit rv, input bit ir,
                      input bit rd, input logic [31:0] rpc);
    drive(r, rdy, rv, ir, rd, rpc);
    tick();
  endtask

  initial begin
    io.imem_req_ready = 1'b0; io.imem_rsp_valid = 1'b0; io.imem_rsp_data = '0;
    io.ins_ready = 1'b0; io.redirect_valid = 1'b0; io.redirect_pc = '0;
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);

    // Streaming with single-cycle memory
    drive(0, 1, 0, 1, 0, 0);
    chk("reset_addr", io.imem_req_addr, RPC);
    chk("reset_ins_valid", 32'(io.ins_valid), 32'd0);
    tick();
    drive(0, 1, 1, 1, 0, 0);
    chk("busy_no_req", 32'(io.imem_req_valid), 32'd0);
    tick();
    drive(0, 1, 0, 1, 0, 0);
    chk("first_ins_pc", io.ins_pc, 32'h0);
    chk("first_ins", io.ins, memfn(32'h0));
    chk("second_addr", io.imem_req_addr, 32'h4);
    tick();
    step(0, 1, 1, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("second_ins_pc", io.ins_pc, 32'h4);
    chk("third_addr", io.imem_req_addr, 32'h8);
    tick();

    // Core stalled: buffer fills, issue stops
    repeat (6) step(0, 1, m_out, 0, 0, 0);
    drive(0, 1, m_out, 0, 0, 0);
    chk("full_no_req", 32'(io.imem_req_valid), 32'd0);
    chk("full_head_pc", io.ins_pc, 32'h4);
    tick();
    repeat (4) step(0, 1, m_out, 1, 0, 0);

    // Redirect with a delayed response in flight
    for (int i = 0; i < 10 && !m_out; i++) step(0, 1, 0, 1, 0, 0);
    step(0, 1, 0, 1, 1, 32'h100);
    step(0, 1, 0, 1, 0, 0);
    step(0, 1, 1, 1, 0, 0);
    drive(0, 1, 0, 1, 0, 0);
    chk("late_word_dropped", 32'(io.ins_valid), 32'd0);
    chk("redir_addr", io.imem_req_addr, 32'h100);
    tick();
    step(0, 1, 1, 1, 0, 0);
    drive(0, 1, 0, 1, 0, 0);
    chk("redir_ins_pc", io.ins_pc, 32'h100);
    tick();

    // Redirect coinciding with a response, unaligned target
    for (int i = 0; i < 10 && !m_out; i++) step(0, 1, 0, 1, 0, 0);
    step(0, 1, 1, 1, 1, 32'h203);
    drive(0, 1, 0, 1, 0, 0);
    chk("same_cycle_drop", 32'(io.ins_valid), 32'd0);
    chk("aligned_addr", io.imem_req_addr, 32'h200);
    tick();

    // Memory not ready: request holds, then withdrawn by redirect
    step(0, 1, 1, 1, 0, 0);
    step(0, 0, 0, 1, 1, 32'h4);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1, 0, 0);
      chk("hold_valid", 32'(io.imem_req_valid), 32'd1);
      chk("hold_addr", io.imem_req_addr, 32'h4);
      tick();
    end
    step(0, 0, 0, 1, 1, 32'h40);
    drive(0, 1, 0, 1, 0, 0);
    chk("withdraw_addr", io.imem_req_addr, 32'h40);
    tick();

    // Reset mid-transaction, then a stale response
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    drive(0, 0, 1, 1, 0, 0);
    chk("rst_mid_ins_valid", 32'(io.ins_valid), 32'd0);
    chk("rst_mid_addr", io.imem_req_addr, RPC);
    tick();
    drive(0, 0, 0, 1, 0, 0);
    chk("stale_ignored", 32'(io.ins_valid), 32'd0);
    tick();

    // PC wrap
    step(0, 0, 0, 1, 1, 32'hFFFF_FFFF);
    drive(0, 1, 0, 1, 0, 0);
    chk("top_addr", io.imem_req_addr, 32'hFFFF_FFFC);
    tick();
    step(0, 1, 1, 1, 0, 0);
    drive(0, 1, 0, 1, 0, 0);
    chk("wrap_addr", io.imem_req_addr, 32'h0);
    chk("top_ins_pc", io.ins_pc, 32'hFFFF_FFFC);
    tick();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      bit r, rdy, rv, ir, rd;
      logic [31:0] rpc;
      r   = ($urandom_range(99) == 0);
      rdy = ($urandom_range(3) != 0);
      rv  = m_out ? ($urandom_range(2) == 0) : ($urandom_range(19) == 0);
      ir  = 1'($urandom_range(1));
      rd  = ($urandom_range(15) == 0);
      rpc = $urandom;
      if ($urandom_range(7) == 0) rpc = 32'hFFFF_FFF0 | 32'($urandom_range(15));
      step(r, rdy, rv, ir, rd, rpc);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
